core_readout: RTL and testbench

- Downstream stage of Core. Once Core has finished computing (its en is deasserted), this block sweeps Core's 11-bit address input and samples Core's 1-bit OUTPUT at each address.
- It packs the sampled bits into bytes and presents them on a valid/ready byte stream for the host link (UART TX or FIFO).
- It replaces bench-style manual address stepping with a hardware sequencer.

---
 rtl/core_pkg.sv | 23 ++
 rtl/core_readout_bit_packer.sv | 42 ++++
 rtl/core_readout.sv | 140 ++++++++++++++
 tb/tb_core_readout.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_pkg : shared defaults, sequencer states and sweep constants   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package core_pkg;

  localparam int ADDR_W_DEF      = 11;
  localparam int BYTE_W_DEF      = 8;
  localparam int RD_LAT_DEF      = 1;
  localparam int BYTES_PER_SWEEP = (2 ** ADDR_W_DEF) / BYTE_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_PUSH   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/core_readout_bit_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bit_packer : LSB-first serial-to-parallel shifter with bit counter |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module bit_packer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_shift,
  input  logic         i_bit,
  output logic [W-1:0] o_word,
  output logic         o_last
);

  localparam int              CNT_W    = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [W-1:0]     r_sr;
  logic [CNT_W-1:0] r_cnt;

  // New bits enter at the MSB so the first bit of a word ends up at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr  <= {i_bit, r_sr[W-1:1]};
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_word = r_sr;
  assign o_last = (r_cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/core_readout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_readout : sweeps Core addresses, packs bits, streams bytes    |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module core_readout
  import core_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] core_addr,
  input  logic              core_bit,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [2:0]        WAIT_LAST = 3'((RD_LAT == 0) ? 0 : RD_LAT - 1);
  // With zero read latency the address is usable immediately, so SETUP is skipped.
  localparam state_t            ST_FETCH  = (RD_LAT == 0) ? ST_SAMPLE : ST_SETUP;

  state_t            r_state;
  logic [ADDR_W-1:0] r_core_addr;
  logic [BYTE_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        r_wait;

  logic              w_accept;
  logic              w_load;
  logic              w_clr;
  logic              w_shift;
  logic [BYTE_W-1:0] w_word;
  logic              w_last;

  assign w_accept = r_m_valid && m_ready;
  assign w_load   = (r_state == ST_PUSH) && (!r_m_valid || m_ready);
  assign w_clr    = w_load || ((r_state == ST_IDLE) && start);
  assign w_shift  = (r_state == ST_SAMPLE);

  bit_packer #(
    .W(BYTE_W)
  ) u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_shift(w_shift),
    .i_bit  (core_bit),
    .o_word (w_word),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_core_addr <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wait      <= '0;
    end else begin
      // Output register: a same-cycle reload from PUSH wins over acceptance.
      if (w_load) begin
        r_m_data  <= w_word;
        r_m_valid <= 1'b1;
      end else if (w_accept) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= ST_SETUP;
            r_core_addr <= '0;
            r_busy      <= 1'b1;
            r_wait      <= '0;
          end
        end
        ST_SETUP: begin
          if (r_wait == WAIT_LAST) begin
            r_state <= ST_SAMPLE;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (w_last) begin
            r_state <= ST_PUSH;
          end else begin
            r_core_addr <= r_core_addr + ADDR_W'(1);
            r_state     <= ST_FETCH;
          end
        end
        ST_PUSH: begin
          if (w_load) begin
            if (r_core_addr == ADDR_LAST) begin
              r_state <= ST_DRAIN;
            end else begin
              r_core_addr <= r_core_addr + ADDR_W'(1);
              r_state     <= ST_FETCH;
            end
          end
        end
        ST_DRAIN: begin
          if (w_accept || !r_m_valid) begin
            r_state     <= ST_FIN;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_core_addr <= '0;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_addr = r_core_addr;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_core_readout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_core_readout : directed self-checking bench for core_readout    |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module tb_core_readout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Instance A: default parameters, registered (1-cycle) Core model
  logic        a_start = 1'b0;
  logic [10:0] a_addr;
  logic        a_bit = 1'b0;
  logic [7:0]  a_data;
  logic        a_valid;
  logic        a_ready = 1'b1;
  logic        a_busy;
  logic        a_done;
  int          a_mode = 0;

  // Instance B: RD_LAT=3, three-stage delayed Core model
  logic        b_start = 1'b0;
  logic [10:0] b_addr;
  logic [2:0]  b_pipe = 3'b000;
  logic [7:0]  b_data;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic        b_busy;
  logic        b_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int a_done_cnt = 0;
  int a_done_busy = 0;
  int a_q_at_done = 0;
  int b_done_cnt = 0;
  int b_done_busy = 0;
  int b_cyc = 0;

  always #5 clk = ~clk;

  core_readout u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .core_addr(a_addr), .core_bit(a_bit),
    .m_data(a_data), .m_valid(a_valid), .m_ready(a_ready), .busy(a_busy), .done(a_done)
  );

  core_readout #(.ADDR_W(11), .RD_LAT(3), .BYTE_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .core_addr(b_addr), .core_bit(b_pipe[2]),
    .m_data(b_data), .m_valid(b_valid), .m_ready(b_ready), .busy(b_busy), .done(b_done)
  );

  always @(posedge clk) begin
    if (a_mode == 0) a_bit <= a_addr[0];
    else             a_bit <= (a_addr == 11'h005) || (a_addr == 11'h7FF);
    b_pipe <= {b_pipe[1:0], b_addr[1]};
  end

  // Inputs change at posedge+1, so a handshake seen here completes on the next posedge.
  always @(negedge clk) begin
    if (a_valid && a_ready) qa.push_back(a_data);
    if (a_done) begin
      a_done_cnt++;
      a_q_at_done = qa.size();
      if (a_busy) a_done_busy++;
    end
    if (b_busy && !(b_valid && qb.size() == 255)) b_cyc++;
    if (b_valid && b_ready) qb.push_back(b_data);
    if (b_done) begin
      b_done_cnt++;
      if (b_busy) b_done_busy++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input string tag, input int base);
    int n = 0;
    while (a_done_cnt == base && n < 12000) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_seen"}, (a_done_cnt > base), 1);
    tick(10);
  endtask

  function automatic int count_ne(input int base, input logic [7:0] val);
    int c = 0;
    for (int i = base; i < qa.size(); i++) if (qa[i] !== val) c++;
    return c;
  endfunction

  initial begin
    int qbase, dbase, errs, n, stable;
    logic [7:0] d0;

    tick(3);
    chk("rst_addr", a_addr, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_data", a_data, 0);
    rst_n = 1'b1;
    tick(3);

    // Pattern sweep: core_bit = addr[0]
    a_mode = 0; a_ready = 1'b1;
    qbase = qa.size(); dbase = a_done_cnt;
    pulse_a_start();
    chk("pat_busy_after_start", a_busy, 1);
    wait_a_done("pat", dbase);
    chk("pat_bytes", qa.size() - qbase, 256);
    chk("pat_all_aa", count_ne(qbase, 8'hAA), 0);
    chk("pat_xfers_at_done", a_q_at_done - qbase, 256);
    chk("pat_one_done", a_done_cnt - dbase, 1);
    chk("pat_idle_addr", a_addr, 0);

    // Address-dependent data
    a_mode = 1;
    qbase = qa.size(); dbase = a_done_cnt;
    pulse_a_start();
    wait_a_done("addr", dbase);
    chk("addr_bytes", qa.size() - qbase, 256);
    chk("addr_byte0", qa[qbase], 8'h20);
    chk("addr_byte255", qa[qbase + 255], 8'h80);
    errs = 0;
    for (int i = qbase + 1; i < qbase + 255; i++) if (qa[i] !== 8'h00) errs++;
    chk("addr_middle_zero", errs, 0);

    // Backpressure
    a_mode = 0; a_ready = 1'b0;
    qbase = qa.size(); dbase = a_done_cnt;
    pulse_a_start();
    n = 0;
    while (!a_valid && n < 200) begin tick(1); n++; end
    chk("bp_first_valid", a_valid, 1);
    d0 = a_data;
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (a_data !== d0 || a_valid !== 1'b1) stable = 0;
    end
    chk("bp_data_stable", stable, 1);
    chk("bp_data_val", d0, 8'hAA);
    chk("bp_addr_held", a_addr, 11'h00F);
    a_ready = 1'b1;
    wait_a_done("bp", dbase);
    chk("bp_bytes", qa.size() - qbase, 256);
    chk("bp_all_aa", count_ne(qbase, 8'hAA), 0);

    // Reset mid-sweep
    a_mode = 1;
    pulse_a_start();
    n = 0;
    while (a_addr !== 11'h123 && n < 3000) begin tick(1); n++; end
    chk("rmid_reach_123", a_addr, 11'h123);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_valid", a_valid, 0);
    chk("rmid_busy", a_busy, 0);
    chk("rmid_addr", a_addr, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    qbase = qa.size(); dbase = a_done_cnt;
    pulse_a_start();
    wait_a_done("rmid", dbase);
    chk("rmid_bytes", qa.size() - qbase, 256);
    chk("rmid_byte0", qa[qbase], 8'h20);
    chk("rmid_byte255", qa[qbase + 255], 8'h80);

    // Spurious start mid-sweep
    a_mode = 0;
    qbase = qa.size(); dbase = a_done_cnt;
    pulse_a_start();
    n = 0;
    while (a_addr !== 11'h040 && n < 1000) begin tick(1); n++; end
    chk("spur_reach_040", a_addr, 11'h040);
    pulse_a_start();
    chk("spur_still_busy", a_busy, 1);
    wait_a_done("spur", dbase);
    tick(20);
    chk("spur_bytes", qa.size() - qbase, 256);
    chk("spur_one_done", a_done_cnt - dbase, 1);
    chk("spur_all_aa", count_ne(qbase, 8'hAA), 0);

    // Latency 3 instance, pattern addr[1]
    b_ready = 1'b1;
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    n = 0;
    while (b_done_cnt == 0 && n < 12000) begin tick(1); n++; end
    chk("lat_done_seen", b_done_cnt, 1);
    tick(10);
    chk("lat_bytes", qb.size(), 256);
    errs = 0;
    foreach (qb[i]) if (qb[i] !== 8'hCC) errs++;
    chk("lat_all_cc", errs, 0);
    chk("lat_cycles", b_cyc, 2048 * 4 + 256);

    chk("done_busy_overlap_a", a_done_busy, 0);
    chk("done_busy_overlap_b", b_done_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
